// File: rtl/partial_sum_accumulator.sv
// partial_sum_accumulator: serially adds the lanes of each beat into a frame total using one ACC_WIDTH adder
module partial_sum_accumulator #(
  parameter int IN_WIDTH  = 9,
  parameter int LANES     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_WIDTH*LANES-1:0] in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [ACC_WIDTH-1:0]      out_sum,
  output logic                      out_overflow,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);
  localparam int IDX_W = $clog2(LANES);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REDUCE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  logic [1:0]                r_state;
  logic [IN_WIDTH*LANES-1:0] r_data;
  logic                      r_last;
  logic [IDX_W-1:0]          r_idx;
  logic [ACC_WIDTH-1:0]      r_acc;
  logic                      r_ovf;
  logic [IN_WIDTH-1:0]       w_lane;
  logic [ACC_WIDTH:0]        w_sum;
  assign w_lane       = r_data[r_idx*IN_WIDTH +: IN_WIDTH];
  assign w_sum        = {1'b0, r_acc} + (ACC_WIDTH+1)'(w_lane);
  assign in_ready     = r_state == S_IDLE;
  assign out_valid    = r_state == S_DONE;
  assign busy         = r_state != S_IDLE;
  assign out_sum      = r_acc;
  assign out_overflow = r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_data  <= in_data;
          r_last  <= in_last;
          r_idx   <= '0;
          r_state <= S_REDUCE;
        end
        S_REDUCE: begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
          r_ovf <= r_ovf | w_sum[ACC_WIDTH];
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(LANES-1)) r_state <= r_last ? S_DONE : S_IDLE;
        end
        S_DONE: if (out_ready) begin
          r_acc   <= '0;
          r_ovf   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_partial_sum_accumulator.sv
// tb_partial_sum_accumulator: random and directed frames on 24-bit and 10-bit instances, scoreboarded
module tb_partial_sum_accumulator;
  localparam int IW = 9;
  localparam int L  = 8;
  typedef struct {longint s; logic o;} res_t;
  logic clk, rst_n, in_valid, in_last, out_ready;
  logic [IW*L-1:0] in_data;
  logic in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [23:0] out_sum_a;
  logic [9:0]  out_sum_b;
  int total = 0, bad = 0;
  res_t qa[$], qb[$];
  int m_cnt;
  logic m_done, m_last, m_rdy, rnd_rdy;
  longint m_tot;
  partial_sum_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_a), .out_sum(out_sum_a), .out_overflow(out_ovf_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a));
  partial_sum_accumulator #(.ACC_WIDTH(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_b), .out_sum(out_sum_b), .out_overflow(out_ovf_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string n, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask
  function automatic longint lane_sum(input logic [IW*L-1:0] d);
    longint s = 0;
    for (int k = 0; k < L; k++) s += longint'(d[k*IW +: IW]);
    return s;
  endfunction
  // Reference: a beat occupies the block for L cycles; a last beat then waits for the output handshake.
  assign m_rdy = (m_cnt == 0) && !m_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_last <= 1'b0;
      m_tot  <= 0;
      qa.delete();
      qb.delete();
    end else if (m_rdy) begin
      if (in_valid) begin
        m_cnt  <= L;
        m_last <= in_last;
        if (in_last) begin
          qa.push_back('{(m_tot + lane_sum(in_data)) % (64'd1 << 24), (m_tot + lane_sum(in_data)) >= (64'd1 << 24)});
          qb.push_back('{(m_tot + lane_sum(in_data)) % 1024, (m_tot + lane_sum(in_data)) >= 1024});
          m_tot <= 0;
        end else m_tot <= m_tot + lane_sum(in_data);
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && m_last) m_done <= 1'b1;
    end else if (out_ready) m_done <= 1'b0;
  end
  always @(negedge clk) begin
    chk("in_ready_a", in_ready_a, m_rdy);
    chk("busy_a", busy_a, !m_rdy);
    chk("out_valid_a", out_valid_a, m_done);
    chk("in_ready_b", in_ready_b, m_rdy);
    chk("out_valid_b", out_valid_b, m_done);
    if (out_valid_a) begin
      if (qa.size() == 0) chk("unexpected_result_a", 1, 0);
      else begin
        chk("sum_a", out_sum_a, qa[0].s);
        chk("ovf_a", out_ovf_a, qa[0].o);
        if (out_ready) void'(qa.pop_front());
      end
    end
    if (out_valid_b) begin
      if (qb.size() == 0) chk("unexpected_result_b", 1, 0);
      else begin
        chk("sum_b", out_sum_b, qb[0].s);
        chk("ovf_b", out_ovf_b, qb[0].o);
        if (out_ready) void'(qb.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic wait_rdy();
    int n = 0;
    while (!m_rdy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_ready_timeout", 0, 1);
  endtask
  task automatic beat(input logic [IW*L-1:0] d, input logic last);
    wait_rdy();
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || !m_rdy) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 0, 1);
  endtask
  function automatic logic [IW*L-1:0] fill(input int v);
    logic [IW*L-1:0] d;
    for (int k = 0; k < L; k++) d[k*IW +: IW] = IW'(v);
    return d;
  endfunction
  function automatic logic [IW*L-1:0] ramp();
    logic [IW*L-1:0] d;
    for (int k = 0; k < L; k++) d[k*IW +: IW] = IW'(k);
    return d;
  endfunction
  initial begin
    int nb;
    logic [IW*L-1:0] d;
    rst_n = 0; in_valid = 0; in_last = 0; in_data = '0; out_ready = 1; rnd_rdy = 0;
    #1;
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_sum", out_sum_a, 0);
    chk("rst_out_ovf", out_ovf_a, 0);
    chk("rst_busy", busy_a, 0);
    repeat (3) tick();
    rst_n = 1;
    tick();
    beat(fill(1), 1);
    drain();
    for (int i = 0; i < 3; i++) beat(ramp(), i == 2);
    drain();
    out_ready = 0;
    beat(fill(5), 1);
    while (!m_done) tick();
    repeat (5) tick();
    out_ready = 1;
    beat(fill(2), 1);
    drain();
    beat(fill(511), 1);
    beat(fill(1), 1);
    drain();
    beat(fill(7), 0);
    repeat (4) tick();
    rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready_a, 1);
    chk("abort_out_valid", out_valid_a, 0);
    chk("abort_out_sum", out_sum_a, 0);
    chk("abort_out_ovf", out_ovf_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_out_sum_b", out_sum_b, 0);
    tick();
    rst_n = 1;
    tick();
    beat(fill(3), 1);
    drain();
    in_data = fill(1); in_last = 0; in_valid = 1;
    for (int c = 0; c < 18; c++) begin
      if (m_cnt != 0) in_last = 1;
      tick();
    end
    in_valid = 0; in_last = 0;
    drain();
    rnd_rdy = 1;
    for (int f = 0; f < 30; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < L; k++) d[k*IW +: IW] = IW'($urandom);
        beat(d, b == nb - 1);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    rnd_rdy = 0;
    out_ready = 1;
    drain();
    repeat (3) tick();
    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
